// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, selects the next PC from the branch
// predictor, and buffers fetched instructions with their prediction metadata
// in a small FIFO toward ID. A mispredict redirect from ID flushes the FIFO.
// Optional build macro FETCH_PERF_CNT_EN adds fetch/redirect event counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] bp_pc,
    input  logic [31:0] bp_target,
    input  logic        bp_taken,
    input  logic [1:0]  bp_state,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_pred_taken,
    output logic [1:0]  id_pred_state,
    output logic [31:0] id_pred_target,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [1:0]  state;
        logic [31:0] target;
    } fq_entry_t;

    logic [31:0] pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    fq_entry_t fq_q [FQ_DEPTH];
    fq_entry_t fq_d [FQ_DEPTH];

    logic full_c;
    logic enq_c;
    logic deq_c;
    fq_entry_t head_c;

    // Queue status and handshakes; fetch stall depends only on registered count
    always_comb begin
        full_c   = (count_q == CNT_W'(FQ_DEPTH));
        imem_req = !redirect_valid && !full_c;
        id_valid = (count_q != '0);
        enq_c    = imem_req;
        deq_c    = id_valid && id_ready && !redirect_valid;
        head_c   = fq_q[rd_ptr_q];
    end

    assign imem_addr      = pc_q;
    assign bp_pc          = pc_q;
    assign id_instr       = head_c.instr;
    assign id_pc          = head_c.pc;
    assign id_pred_taken  = head_c.taken;
    assign id_pred_state  = head_c.state;
    assign id_pred_target = head_c.target;

    // Next PC, pointer and occupancy selection; redirect overrides everything
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            if (enq_c) begin
                pc_d     = bp_taken ? {bp_target[31:2], 2'b00} : (pc_q + 32'd4);
                wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
            end
            if (deq_c) begin
                rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
            end
            case ({enq_c, deq_c})
                2'b10:   count_d = CNT_W'(count_q + CNT_W'(1));
                2'b01:   count_d = CNT_W'(count_q - CNT_W'(1));
                default: count_d = count_q;
            endcase
        end
    end

    // Queue storage write: capture fetched instruction and prediction at the tail
    always_comb begin
        for (int i = 0; i < FQ_DEPTH; i++) begin
            fq_d[i] = fq_q[i];
        end
        if (enq_c) begin
            fq_d[wr_ptr_q] = '{pc: pc_q, instr: imem_rdata, taken: bp_taken,
                               state: bp_state, target: bp_target};
        end
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Queue storage registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                fq_q[i] <= fq_d[i];
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_redirects_q, perf_redirects_d;

    // Event counters: one per enqueue, one per redirect cycle, free-running wrap
    always_comb begin
        perf_fetched_d   = perf_fetched_q;
        perf_redirects_d = perf_redirects_q;
        if (enq_c) begin
            perf_fetched_d = perf_fetched_q + 32'd1;
        end
        if (redirect_valid) begin
            perf_redirects_d = perf_redirects_q + 32'd1;
        end
    end

    // Event counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched_q   <= '0;
            perf_redirects_q <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_redirects_q <= perf_redirects_d;
        end
    end

    assign perf_fetched   = perf_fetched_q;
    assign perf_redirects = perf_redirects_q;
`else
    assign perf_fetched   = 32'd0;
    assign perf_redirects = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: table of single-cycle vectors for the
// sequential fetch / prediction / redirect flow, plus hand-written sequences
// for queue fill/stall, redirect-on-full, PC wrap and asynchronous reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] bp_pc;
    logic [31:0] bp_target;
    logic        bp_taken;
    logic [1:0]  bp_state;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_pred_taken;
    logic [1:0]  id_pred_state;
    logic [31:0] id_pred_target;
    logic [31:0] perf_fetched;
    logic [31:0] perf_redirects;

    int checks;
    int errors;

    fetch_stage #(
        .RESET_PC(32'h0000_0100),
        .FQ_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .bp_pc(bp_pc), .bp_target(bp_target), .bp_taken(bp_taken), .bp_state(bp_state),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
        .id_pred_taken(id_pred_taken), .id_pred_state(id_pred_state),
        .id_pred_target(id_pred_target),
        .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
    );

    // Instruction memory model: content is a fixed scramble of the address
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rdy;
        logic        tk;
        logic [31:0] tgt;
        logic [1:0]  st;
        logic        rv;
        logic [31:0] rpc;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_tk;
        logic [31:0] e_tgt;
        logic [1:0]  e_st;
    } vec_t;

    vec_t vecs [11];
    logic [31:0] exp_fetched;
    logic [31:0] exp_redirects;

    initial begin
        checks = 0;
        errors = 0;

        //          rdy tk tgt          st    rv rpc           addr          v  pc            tk tgt          st
        vecs[0]  = '{1, 0, 32'h104, 2'd0, 0, 32'h0,   32'h104, 1, 32'h100, 0, 32'h104, 2'd0};
        vecs[1]  = '{1, 0, 32'h108, 2'd1, 0, 32'h0,   32'h108, 1, 32'h104, 0, 32'h108, 2'd1};
        vecs[2]  = '{1, 0, 32'h10C, 2'd2, 0, 32'h0,   32'h10C, 1, 32'h108, 0, 32'h10C, 2'd2};
        vecs[3]  = '{1, 0, 32'h110, 2'd1, 0, 32'h0,   32'h110, 1, 32'h10C, 0, 32'h110, 2'd1};
        vecs[4]  = '{1, 0, 32'h114, 2'd0, 0, 32'h0,   32'h114, 1, 32'h110, 0, 32'h114, 2'd0};
        vecs[5]  = '{1, 0, 32'h118, 2'd0, 1, 32'h10B, 32'h108, 0, 32'h0,   0, 32'h0,   2'd0};
        vecs[6]  = '{0, 1, 32'h200, 2'd3, 0, 32'h0,   32'h200, 1, 32'h108, 1, 32'h200, 2'd3};
        vecs[7]  = '{1, 0, 32'h204, 2'd1, 0, 32'h0,   32'h204, 1, 32'h200, 0, 32'h204, 2'd1};
        vecs[8]  = '{1, 1, 32'h3FE, 2'd2, 0, 32'h0,   32'h3FC, 1, 32'h204, 1, 32'h3FE, 2'd2};
        vecs[9]  = '{1, 0, 32'h400, 2'd0, 0, 32'h0,   32'h400, 1, 32'h3FC, 0, 32'h400, 2'd0};
        vecs[10] = '{1, 0, 32'h404, 2'd1, 0, 32'h0,   32'h404, 1, 32'h400, 0, 32'h404, 2'd1};

        rst = 1'b1;
        id_ready = 1'b0;
        bp_taken = 1'b0;
        bp_target = 32'h0;
        bp_state = 2'd0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        // Reset state
        @(negedge clk);
        chk("rst_imem_addr", imem_addr, 32'h100);
        chk("rst_bp_pc", bp_pc, 32'h100);
        chk("rst_id_valid", 32'(id_valid), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_perf_fetched", perf_fetched, 32'd0);
        chk("rst_perf_redirects", perf_redirects, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 11; i++) begin
            id_ready       = vecs[i].rdy;
            bp_taken       = vecs[i].tk;
            bp_target      = vecs[i].tgt;
            bp_state       = vecs[i].st;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rpc;
            step();
            chk($sformatf("v%0d_imem_addr", i), imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(vecs[i].e_valid));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_id_pc", i), id_pc, vecs[i].e_pc);
                chk($sformatf("v%0d_id_instr", i), id_instr, instr_of(vecs[i].e_pc));
                chk($sformatf("v%0d_pred_taken", i), 32'(id_pred_taken), 32'(vecs[i].e_tk));
                chk($sformatf("v%0d_pred_target", i), id_pred_target, vecs[i].e_tgt);
                chk($sformatf("v%0d_pred_state", i), 32'(id_pred_state), 32'(vecs[i].e_st));
            end
        end

        // Fill the queue with ID stalled, then release it for one cycle
        bp_taken = 1'b0;
        bp_target = 32'h0;
        bp_state = 2'd0;
        id_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        step();
        redirect_valid = 1'b0;
        chk("fill_start_addr", imem_addr, 32'h500);
        chk("fill_start_valid", 32'(id_valid), 32'd0);
        for (int i = 0; i < 4; i++) step();
        chk("full_imem_req", 32'(imem_req), 32'd0);
        chk("full_imem_addr", imem_addr, 32'h510);
        chk("full_id_pc", id_pc, 32'h500);
        step();
        chk("full_pc_frozen", imem_addr, 32'h510);
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("drain1_addr", imem_addr, 32'h510);
        chk("drain1_id_pc", id_pc, 32'h504);
        chk("drain1_imem_req", 32'(imem_req), 32'd1);
        step();
        chk("refill_addr", imem_addr, 32'h514);
        chk("refill_imem_req", 32'(imem_req), 32'd0);

        // Redirect on a full queue with ID ready
        id_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h403;
        #1;
        chk("redir_imem_req", 32'(imem_req), 32'd0);
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        chk("redir_id_valid", 32'(id_valid), 32'd0);
        chk("redir_imem_addr", imem_addr, 32'h400);
        #1;
        chk("post_redir_imem_req", 32'(imem_req), 32'd1);
        step();
        chk("post_redir_id_valid", 32'(id_valid), 32'd1);
        chk("post_redir_id_pc", id_pc, 32'h400);
        chk("post_redir_addr", imem_addr, 32'h404);

        // PC increment wraps past the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect_valid = 1'b0;
        chk("wrap_start_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);

        // Event counters: 17 enqueues and 4 redirect cycles so far
`ifdef FETCH_PERF_CNT_EN
        exp_fetched = 32'd17;
        exp_redirects = 32'd4;
`else
        exp_fetched = 32'd0;
        exp_redirects = 32'd0;
`endif
        chk("perf_fetched", perf_fetched, exp_fetched);
        chk("perf_redirects", perf_redirects, exp_redirects);

        // Asynchronous reset mid-operation, asserted away from any clock edge
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_addr", imem_addr, 32'h100);
        chk("async_rst_valid", 32'(id_valid), 32'd0);
        chk("async_rst_perf", perf_fetched, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("after_rst_id_pc", id_pc, 32'h100);
        chk("after_rst_addr", imem_addr, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
